serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial arithmetic stage for the SSEM datapath.
- Holds the accumulator and streams the accumulator and operand LSB-first through a one-bit full-adder slice, with a registered carry.
- Implements the two SSEM arithmetic orders:
  - LDN: A := -S
  - SUB: A := A - S
- Sits between the store read path, which supplies the parallel operand, and the control unit, which issues start and samples done, result and sign.

Parameters:
WIDTH, 32, word length in bits; also the number of serial steps per operation.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
io_start  input  1  request pulse. Sampled only in IDLE.
io_op  input  1  operation: 0 = LDN, 1 = SUB. Latched with io_start.
io_operand  input  WIDTH  operand S. Latched with io_start.
io_busy  output  1  high while serial steps are in progress.
io_done  output  1  one-cycle pulse when the result is complete.
io_acc  output  WIDTH  accumulator. Valid whenever io_busy is low.
io_negative  output  1  io_acc[WIDTH-1]. Valid whenever io_busy is low.
io_carry_out  output  1  final carry of the last completed operation.

Behaviour:
- Synchronous reset (reset high at a clock edge):
  - state = IDLE, accumulator = 0, operand shift register = 0, carry = 0, step counter = 0, latched op = 0, io_carry_out = 0.
  - Outputs therefore: io_busy = 0, io_done = 0, io_acc = 0, io_negative = 0.
  - Reset wins over every other event, including mid-SHIFT; a partial result is discarded.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE, io_start = 1: latch io_op, load io_operand into the S shift register, carry := 1, counter := 0, go to SHIFT.
  - IDLE, io_start = 0: hold all state.
  - SHIFT, each cycle:
    - a = acc[0] when op = SUB; a = 0 when op = LDN.
    - s = ~S[0].
    - sum = a ^ s ^ carry.
    - carry := (a & s) | (a & carry) | (s & carry).
    - acc := {sum, acc[WIDTH-1:1]}; S := S >> 1; counter := counter + 1.
  - SHIFT with counter == WIDTH-1: perform the step, latch io_carry_out from the final carry, go to DONE.
  - DONE: io_done = 1 for exactly this cycle, then IDLE.
- Outputs by state:
  - io_busy = 1 exactly in SHIFT.
  - io_done is 0 outside DONE.
- Latency: io_start sampled at edge T gives SHIFT for cycles T+1 .. T+WIDTH, DONE in cycle T+WIDTH+1. The next start is accepted at edge T+WIDTH+2 at the earliest.
- Ignored inputs:
  - io_start in SHIFT or DONE is ignored: no queuing, no effect.
  - io_op and io_operand are ignored outside the accepting edge.
- Arithmetic: two's-complement modulo 2^WIDTH; there is no overflow flag.
  - io_carry_out = 1 means no borrow (A >= S unsigned for SUB; S == 0 for LDN).
- Counter width is clog2(WIDTH). No wrap occurs because the terminal count is WIDTH-1.
- io_acc during SHIFT shows a rotating partial value; consumers must not sample it.

Test Plan:
- Reset then idle -> io_acc = 0, io_busy = 0, io_done = 0, io_negative = 0, io_carry_out = 0.
- LDN with operand 0x00000001 -> busy for 32 cycles; done in cycle 33 after start; io_acc = 0xFFFFFFFF; io_negative = 1; io_carry_out = 0.
- LDN 0xFFFFFFFB (acc = 5), then SUB 0x00000003 -> io_acc = 0x00000002, io_negative = 0, io_carry_out = 1.
- From acc = 0, SUB 0x00000001 -> io_acc = 0xFFFFFFFF, io_carry_out = 0. Then SUB 0x80000000 -> io_acc = 0x7FFFFFFF, io_negative = 0.
- io_start pulsed with a different operand at SHIFT cycles 5 and 32, and in the DONE cycle -> result unchanged; exactly one io_done pulse.
- reset asserted in SHIFT cycle 10 of SUB -> next cycle io_busy = 0, io_acc = 0, no io_done. A subsequent LDN 0x00000002 -> 0xFFFFFFFE.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LDN/SUB stage for the SSEM datapath: streams accumulator and
// inverted operand LSB-first through one full-adder slice with a registered carry.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_op,
    input  logic [WIDTH-1:0] io_operand,
    output logic             io_busy,
    output logic             io_done,
    output logic [WIDTH-1:0] io_acc,
    output logic             io_negative,
    output logic             io_carry_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One-bit full adder, returned as {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] acc_r, acc_nxt_s;
    logic [WIDTH-1:0] opnd_r, opnd_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic             op_r, op_nxt_s;
    logic             cout_r, cout_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             a_bit_s;
    logic             s_bit_s;
    logic [1:0]       fa_s;

    // Next-state, datapath step and next-output decode.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        opnd_nxt_s  = opnd_r;
        cnt_nxt_s   = cnt_r;
        carry_nxt_s = carry_r;
        op_nxt_s    = op_r;
        cout_nxt_s  = cout_r;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        a_bit_s     = 1'b0;
        s_bit_s     = 1'b0;
        fa_s        = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (io_start) begin
                    op_nxt_s    = io_op;
                    opnd_nxt_s  = io_operand;
                    carry_nxt_s = 1'b1;
                    cnt_nxt_s   = '0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // LDN treats the accumulator input as zero, so the result is 0 - S.
                a_bit_s     = (op_r == OP_SUB) ? acc_r[0] : 1'b0;
                s_bit_s     = ~opnd_r[0];
                fa_s        = full_add(a_bit_s, s_bit_s, carry_r);
                acc_nxt_s   = {fa_s[0], acc_r[WIDTH-1:1]};
                opnd_nxt_s  = {1'b0, opnd_r[WIDTH-1:1]};
                carry_nxt_s = fa_s[1];
                if (cnt_r == LAST_STEP) begin
                    cnt_nxt_s   = '0;
                    cout_nxt_s  = fa_s[1];
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            opnd_r  <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            op_r    <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            opnd_r  <= opnd_nxt_s;
            cnt_r   <= cnt_nxt_s;
            carry_r <= carry_nxt_s;
            op_r    <= op_nxt_s;
            cout_r  <= cout_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign io_busy      = busy_r;
    assign io_done      = done_r;
    assign io_acc       = acc_r;
    assign io_negative  = acc_r[WIDTH-1];
    assign io_carry_out = cout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// LDN/SUB traffic compared against a plain-arithmetic accumulator model.
module tb_serial_subtractor;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         io_start;
    logic         io_op;
    logic [W-1:0] io_operand;
    logic         io_busy;
    logic         io_done;
    logic [W-1:0] io_acc;
    logic         io_negative;
    logic         io_carry_out;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] acc_m;
    logic         cout_m;

    serial_subtractor #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_op        (io_op),
        .io_operand   (io_operand),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_acc       (io_acc),
        .io_negative  (io_negative),
        .io_carry_out (io_carry_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: two's-complement arithmetic, carry = "no borrow".
    task automatic model_op(input logic op, input logic [W-1:0] s);
        if (op) begin
            cout_m = (acc_m >= s);
            acc_m  = acc_m - s;
        end else begin
            cout_m = (s == '0);
            acc_m  = '0 - s;
        end
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_acc"}, io_acc, acc_m);
        chk({tag, "_neg"}, {{(W-1){1'b0}}, io_negative}, {{(W-1){1'b0}}, acc_m[W-1]});
        chk({tag, "_cout"}, {{(W-1){1'b0}}, io_carry_out}, {{(W-1){1'b0}}, cout_m});
    endtask

    // Issue one operation; optionally pulse start in SHIFT cycles 5 and W and in DONE.
    task automatic do_op(input string tag, input logic op, input logic [W-1:0] s, input bit inject);
        int busy_ok;
        @(negedge clock);
        io_start = 1'b1; io_op = op; io_operand = s;
        @(negedge clock);
        io_start = 1'b0; io_op = 1'($urandom); io_operand = $urandom;
        model_op(op, s);
        busy_ok = 0;
        for (int k = 1; k <= W; k++) begin
            if (io_busy === 1'b1 && io_done === 1'b0) busy_ok++;
            if (inject && (k == 5 || k == W)) begin
                io_start = 1'b1; io_op = ~op; io_operand = ~s;
            end else begin
                io_start = 1'b0;
            end
            @(negedge clock);
        end
        io_start = inject;
        chk({tag, "_busy_cycles"}, W'(busy_ok), W'(W));
        chk({tag, "_done_pulse"}, {{(W-1){1'b0}}, io_done}, {{(W-1){1'b0}}, 1'b1});
        chk({tag, "_busy_in_done"}, {{(W-1){1'b0}}, io_busy}, '0);
        check_result(tag);
        @(negedge clock);
        io_start = 1'b0;
        chk({tag, "_done_low"}, {{(W-1){1'b0}}, io_done}, '0);
        chk({tag, "_idle_busy"}, {{(W-1){1'b0}}, io_busy}, '0);
    endtask

    initial begin
        int dones;
        logic         rop;
        logic [W-1:0] rs;

        reset = 1'b1; io_start = 1'b0; io_op = 1'b0; io_operand = '0;
        acc_m = '0; cout_m = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_acc", io_acc, '0);
        chk("rst_busy", {{(W-1){1'b0}}, io_busy}, '0);
        chk("rst_done", {{(W-1){1'b0}}, io_done}, '0);
        chk("rst_neg", {{(W-1){1'b0}}, io_negative}, '0);
        chk("rst_cout", {{(W-1){1'b0}}, io_carry_out}, '0);

        do_op("ldn_1", 1'b0, 32'h0000_0001, 1'b0);
        do_op("ldn_fffffffb", 1'b0, 32'hFFFF_FFFB, 1'b0);
        do_op("sub_3", 1'b1, 32'h0000_0003, 1'b0);
        do_op("ldn_0", 1'b0, 32'h0000_0000, 1'b0);
        do_op("sub_1_from_0", 1'b1, 32'h0000_0001, 1'b0);
        do_op("sub_80000000", 1'b1, 32'h8000_0000, 1'b0);
        do_op("inject", 1'b1, 32'h0000_0055, 1'b1);

        // Reset in SHIFT cycle 10 discards the partial result.
        @(negedge clock);
        io_start = 1'b1; io_op = 1'b1; io_operand = 32'h0001_2345;
        @(negedge clock);
        io_start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        acc_m = '0; cout_m = 1'b0;
        chk("midrst_busy", {{(W-1){1'b0}}, io_busy}, '0);
        chk("midrst_done", {{(W-1){1'b0}}, io_done}, '0);
        check_result("midrst");
        dones = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (io_done === 1'b1 || io_busy === 1'b1) dones++;
            @(negedge clock);
        end
        chk("midrst_no_activity", W'(dones), '0);
        do_op("ldn_2_after_rst", 1'b0, 32'h0000_0002, 1'b0);

        // Idle with stray op/operand and no start holds state.
        for (int k = 0; k < 5; k++) begin
            io_op = 1'($urandom); io_operand = $urandom;
            @(negedge clock);
        end
        check_result("idle_hold");

        for (int n = 0; n < 24; n++) begin
            rop = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       rs = '0;
                1:       rs = '1;
                2:       rs = 32'h8000_0000;
                3:       rs = acc_m;
                default: rs = $urandom;
            endcase
            do_op($sformatf("rand%0d", n), rop, rs, 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
